// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   - Requester count and datapath width
//   - ALU control codes understood by the shared ALU
//   - Flag bit positions inside the 3-bit {carry, negative, zero} vector
//   - FSM state encoding and the operand-register layout
package alu_arbiter_pkg;

    localparam int NREQ = 2;
    localparam int DW   = 32;

    // ALU control codes (decoded by the shared ALU, not by the arbiter)
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1100;

    // Flag bit indices
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_ZERO  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] input1;
        logic [DW-1:0] input2;
        logic [4:0]    shamt;
        logic [3:0]    control;
    } operand_t;

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin selector.
//   valid[1:0]  : requesters currently asking
//   last_grant  : index of the requester granted most recently
//   grant[1:0]  : one-hot winner (all zero when nobody is valid)
// A lone requester always wins; on a tie the one not granted last wins.
module alu_rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] valid,
    input  logic            last_grant,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        grant = '0;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters.
//   clk, rst                 : clock and synchronous active-high reset
//   req_valid / req_ready    : per-requester request handshake
//   req_input1/2, req_shamt,
//   req_control              : per-requester operands, packed {req1, req0}
//   alu_input1/2, alu_shamt,
//   alu_control              : operands driven to the shared ALU (registered)
//   alu_out, alu_flags       : ALU result and {carry, negative, zero}
//   resp_valid / resp_ready  : result handshake
//   resp_id, resp_out,
//   resp_flags               : registered result and its owner
//   flags_q                  : architectural flags, updated only by FLAG_SRC
// Flow: IDLE -accept-> EXEC -> RESP -handshake-> IDLE, or straight back to
// EXEC when a new request is accepted in the handshake cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int FLAG_SRC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_input1,
    input  logic [NREQ*DW-1:0] req_input2,
    input  logic [NREQ*5-1:0]  req_shamt,
    input  logic [NREQ*4-1:0]  req_control,
    output logic [DW-1:0]      alu_input1,
    output logic [DW-1:0]      alu_input2,
    output logic [4:0]         alu_shamt,
    output logic [3:0]         alu_control,
    input  logic [DW-1:0]      alu_out,
    input  logic [2:0]         alu_flags,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [DW-1:0]      resp_out,
    output logic [2:0]         resp_flags,
    output logic [2:0]         flags_q
);

    localparam logic FLAG_ID = FLAG_SRC[0];

    state_t          state_reg, state_next;
    operand_t        op_reg;
    operand_t        req_op [NREQ];
    logic            op_id_reg;
    logic            last_grant_reg;
    logic            resp_id_reg;
    logic [DW-1:0]   resp_out_reg;
    logic [2:0]      resp_flags_reg;
    logic [2:0]      flags_q_reg;
    logic [NREQ-1:0] grant;
    logic            win_id;
    logic            can_accept;
    logic            accept;
    logic            handshake;

    // Unpack the per-requester operand buses
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_op[gi] = '{
                input1:  req_input1[gi*DW +: DW],
                input2:  req_input2[gi*DW +: DW],
                shamt:   req_shamt[gi*5 +: 5],
                control: req_control[gi*4 +: 4]
            };
        end
    endgenerate

    alu_rr_arb2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    assign win_id = grant[1];

    // A new operand can be taken when idle, or when the pending result
    // leaves this very cycle. Reset blocks acceptance outright.
    assign can_accept = !rst && ((state_reg == IDLE) ||
                                 (state_reg == RESP && resp_ready));
    assign req_ready  = can_accept ? grant : '0;
    assign accept     = |req_ready;

    assign resp_valid = (state_reg == RESP);
    assign handshake  = resp_valid && resp_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready) state_next = accept ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            op_reg         <= '0;
            op_id_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            resp_id_reg    <= 1'b0;
            resp_out_reg   <= '0;
            resp_flags_reg <= '0;
            flags_q_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg         <= req_op[win_id];
                op_id_reg      <= win_id;
                last_grant_reg <= win_id;
            end
            // Result is only captured on the EXEC->RESP edge, so it stays
            // frozen for the whole RESP stall.
            if (state_reg == EXEC) begin
                resp_out_reg   <= alu_out;
                resp_flags_reg <= alu_flags;
                resp_id_reg    <= op_id_reg;
            end
            if (handshake && resp_id_reg == FLAG_ID) begin
                flags_q_reg <= resp_flags_reg;
            end
        end
    end

    assign alu_input1  = op_reg.input1;
    assign alu_input2  = op_reg.input2;
    assign alu_shamt   = op_reg.shamt;
    assign alu_control = op_reg.control;
    assign resp_id     = resp_id_reg;
    assign resp_out    = resp_out_reg;
    assign resp_flags  = resp_flags_reg;
    assign flags_q     = flags_q_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_input1, req_input2;
    logic [9:0]  req_shamt;
    logic [7:0]  req_control;
    logic [31:0] alu_input1, alu_input2, alu_out;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_control;
    logic [2:0]  alu_flags;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_out;
    logic [2:0]  resp_flags, flags_q;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [2:0] flags_model;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    alu_arbiter #(.FLAG_SRC(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_input1(req_input1), .req_input2(req_input2),
        .req_shamt(req_shamt), .req_control(req_control),
        .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shamt(alu_shamt), .alu_control(alu_control),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_out(resp_out), .resp_flags(resp_flags), .flags_q(flags_q)
    );

    // Behavioural model of the shared ALU
    logic [31:0] alu_res;
    logic        alu_c;
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (alu_control)
            ALU_ADD: {alu_c, alu_res} = {1'b0, alu_input1} + {1'b0, alu_input2};
            ALU_SUB: {alu_c, alu_res} = {1'b0, alu_input1} + {1'b0, ~alu_input2} + 33'd1;
            ALU_SLL: alu_res = alu_input1 << alu_shamt;
            ALU_SRA: alu_res = $signed(alu_input1) >>> alu_input2[4:0];
            default: alu_res = alu_input1 & alu_input2;
        endcase
    end
    assign alu_out   = alu_res;
    assign alu_flags = {alu_c, alu_res[31], alu_res == 32'd0};

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [3:0]  ctl;
        logic [31:0] exp_out;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs [8];

    // Results captured by run_pair
    logic        rec_id  [8];
    logic [31:0] rec_out [8];
    logic [2:0]  rec_flg [8];
    logic [2:0]  rec_fq  [8];
    int          rec_cyc [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [3:0] ctl);
        req_input1[id*32 +: 32] = a;
        req_input2[id*32 +: 32] = b;
        req_shamt[id*5 +: 5]    = sh;
        req_control[id*4 +: 4]  = ctl;
    endtask

    // Single request from idle with resp_ready=1; called at a negedge.
    task automatic run_op(input vec_t v);
        int n;
        int t0;
        logic [1:0] exp_rdy;
        set_req(v.id, v.a, v.b, v.sh, v.ctl);
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        resp_ready = 1'b1;
        exp_rdy = '0;
        exp_rdy[v.id] = 1'b1;
        #1;
        chk("ready_idle", req_ready, exp_rdy);
        n = 0;
        while (!req_ready[v.id] && n < 8) begin
            @(negedge clk); #1; n++;
        end
        t0 = cycle;
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (!resp_valid && n < 8) begin
            @(negedge clk); n++;
        end
        chk("resp_valid", resp_valid, 1);
        chk("latency", cycle - t0, 2);
        chk("resp_id", resp_id, v.id);
        chk("resp_out", resp_out, v.exp_out);
        chk("resp_flags", resp_flags, v.exp_flags);
        $display("txn id=%0d ctl=%b a=%h b=%h -> out=%h flags=%b", v.id, v.ctl, v.a, v.b, resp_out, resp_flags);
        @(negedge clk);
        if (v.id == 1'b0) flags_model = v.exp_flags;
        chk("flags_q", flags_q, flags_model);
        chk("resp_valid_drop", resp_valid, 0);
    endtask

    // Both requesters valid with resp_ready=1; collects nops results.
    // With drop=1 a requester withdraws once accepted. Called at a negedge.
    task automatic run_pair(input int nops, input bit drop);
        int got;
        bit hs_prev;
        logic [1:0] acc_prev;
        got = 0;
        hs_prev = 0;
        acc_prev = '0;
        req_valid = 2'b11;
        resp_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (hs_prev) rec_fq[got-1] = flags_q;
            if (got == nops) break;
            if (resp_valid) begin
                rec_id[got]  = resp_id;
                rec_out[got] = resp_out;
                rec_flg[got] = resp_flags;
                rec_cyc[got] = cycle;
                $display("txn id=%0d -> out=%h flags=%b cycle=%0d", resp_id, resp_out, resp_flags, cycle);
                got++;
                hs_prev = 1;
            end else begin
                hs_prev = 0;
            end
            acc_prev = req_ready;
            @(negedge clk);
            if (drop) req_valid = req_valid & ~acc_prev;
        end
        req_valid = '0;
        chk("pair_count", got, nops);
    endtask

    task automatic drain();
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'd105,        32'd106,        5'd0, ALU_ADD, 32'd211,        3'b000};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          5'd0, ALU_ADD, 32'd1,          3'b100};
        vecs[2] = '{1'b1, 32'hFFFF_FEFD,  32'd8,          5'd0, ALU_SRA, 32'hFFFF_FFFE,  3'b010};
        vecs[3] = '{1'b0, 32'd5,          32'd7,          5'd0, ALU_SUB, 32'hFFFF_FFFE,  3'b010};
        vecs[4] = '{1'b1, 32'd3,          32'd0,          5'd4, ALU_SLL, 32'd48,         3'b000};
        vecs[5] = '{1'b0, 32'h8000_0000,  32'd31,         5'd0, ALU_SRA, 32'hFFFF_FFFF,  3'b010};
        vecs[6] = '{1'b1, 32'h8000_0000,  32'h8000_0000,  5'd0, ALU_ADD, 32'd0,          3'b101};
        vecs[7] = '{1'b0, 32'd0,          32'd0,          5'd0, ALU_ADD, 32'd0,          3'b001};

        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b0;
        req_input1 = '0; req_input2 = '0; req_shamt = '0; req_control = '0;
        flags_model = 3'b000;
        repeat (3) @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_out", resp_out, 0);
        chk("rst_resp_flags", resp_flags, 0);
        chk("rst_flags_q", flags_q, 0);
        chk("rst_alu_in1", alu_input1, 0);
        chk("rst_alu_in2", alu_input2, 0);
        chk("rst_alu_ctl", {alu_shamt, alu_control}, 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Tie after reset: req0 first, then req1; only req0 touches flags_q
        set_req(1'b0, 32'h8000_0000, 32'h8000_0000, 5'd0, ALU_ADD);
        set_req(1'b1, 32'd105, 32'd106, 5'd0, ALU_ADD);
        run_pair(2, 1);
        chk("tie_id0", rec_id[0], 0);
        chk("tie_out0", rec_out[0], 0);
        chk("tie_flg0", rec_flg[0], 3'b101);
        chk("tie_fq0", rec_fq[0], 3'b101);
        chk("tie_id1", rec_id[1], 1);
        chk("tie_out1", rec_out[1], 211);
        chk("tie_flg1", rec_flg[1], 3'b000);
        chk("tie_fq1", rec_fq[1], 3'b101);
        drain();

        // Both held valid: grants alternate, results 2 cycles apart
        set_req(1'b0, 32'd1, 32'd1, 5'd0, ALU_ADD);
        set_req(1'b1, 32'd3, 32'd4, 5'd0, ALU_ADD);
        run_pair(4, 0);
        for (int i = 0; i < 4; i++) begin
            chk("rr_id", rec_id[i], i % 2);
            chk("rr_out", rec_out[i], (i % 2) ? 32'd7 : 32'd2);
        end
        chk("rr_fq_changed", rec_fq[0], 3'b000);
        for (int i = 0; i < 3; i++) chk("rr_gap", rec_cyc[i+1] - rec_cyc[i], 2);
        drain();
        flags_model = 3'b000;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Stall in RESP with a second request waiting
        set_req(1'b0, 32'h8000_0000, 32'h8000_0000, 5'd0, ALU_ADD);
        set_req(1'b1, 32'd7, 32'd8, 5'd0, ALU_ADD);
        req_valid = 2'b01;
        resp_ready = 1'b0;
        #1;
        chk("stall_ready_idle", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("stall_ready_exec", req_ready, 2'b00);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", resp_valid, 1);
            chk("stall_out", resp_out, 0);
            chk("stall_flags", resp_flags, 3'b101);
            chk("stall_id", resp_id, 0);
            chk("stall_ready", req_ready, 2'b00);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        chk("release_ready", req_ready, 2'b10);
        $display("txn id=0 stalled -> out=%h flags=%b", resp_out, resp_flags);
        @(negedge clk);
        req_valid = '0;
        flags_model = 3'b101;
        chk("release_fq", flags_q, flags_model);
        chk("release_gap", resp_valid, 0);
        @(negedge clk);
        chk("b2b_valid", resp_valid, 1);
        chk("b2b_id", resp_id, 1);
        chk("b2b_out", resp_out, 15);
        $display("txn id=1 back-to-back -> out=%h flags=%b", resp_out, resp_flags);
        @(negedge clk);
        chk("b2b_fq", flags_q, flags_model);

        // Reset while in EXEC discards the in-flight result
        set_req(1'b0, 32'h8000_0000, 32'h8000_0000, 5'd0, ALU_ADD);
        req_valid = 2'b01;
        #1;
        chk("pre_rst_ready", req_ready, 2'b01);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("exec_rst_valid", resp_valid, 0);
        chk("exec_rst_fq", flags_q, 0);
        chk("exec_rst_out", resp_out, 0);
        chk("exec_rst_alu", alu_input1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("exec_rst_quiet", resp_valid, 0);
        end
        chk("exec_rst_fq_hold", flags_q, 0);
        flags_model = 3'b000;
        run_op(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FLAG_SRC, default 0: index of the requester whose completed operations update flags_q.
REQ-002 SHALL use one clock and one reset: clk, synchronous, active-high reset rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept; a request transfers on valid&&ready.
REQ-007 req_input1, req_input2  input  2x32 each  signed operands, packed {req1, req0}.
REQ-008 req_shamt  input  2x5  immediate shift amount, packed {req1, req0}.
REQ-009 req_control  input  2x4  ALU control code, packed {req1, req0}.
REQ-010 alu_input1, alu_input2  output  32 each  operands to the shared alu.
REQ-011 alu_shamt  output  5  and alu_control  output  4  drive the shared alu.
REQ-012 alu_out  input  32  and alu_flags  input  3 {carry, negative, zero} from the alu.
REQ-013 resp_valid  output  1, resp_ready  input  1: result handshake.
REQ-014 resp_id  output  1  requester that owns the result.
REQ-015 resp_out  output  32  and resp_flags  output  3: registered result and flags.
REQ-016 flags_q  output  3  architectural flags {carry, negative, zero} for branch logic.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; the only legal transitions are IDLE->EXEC, EXEC->RESP, RESP->IDLE and RESP->EXEC.
REQ-018 req_ready SHALL be nonzero only in IDLE, or in RESP when resp_ready=1; at most one bit is set, and it is set only for the granted requester with req_valid=1.
REQ-019 Arbitration is 2-way round-robin: a sole valid requester wins; when both are valid, the requester not granted last wins; last_grant resets to 1, so req0 wins the first tie.
REQ-020 On accept, the operand register loads input1/input2/shamt/control of the winner, its id is stored, and the FSM enters EXEC.
REQ-021 alu_* outputs SHALL come straight from the operand register; the alu path is combinational within EXEC.
REQ-022 At the EXEC->RESP edge, resp_out/resp_flags capture alu_out/alu_flags and resp_valid rises; latency from the accept edge to resp_valid is 2 cycles.
REQ-023 resp_out, resp_flags and resp_id SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-024 On resp_valid&&resp_ready: the FSM enters EXEC if a new request is accepted in the same cycle (back-to-back), otherwise IDLE; resp_valid falls unless re-set by EXEC->RESP.
REQ-025 flags_q SHALL load resp_flags at the handshake cycle only when resp_id==FLAG_SRC; results for the other requester leave flags_q unchanged.
REQ-026 Requests arriving in EXEC, or in RESP with resp_ready=0, are not accepted; a request's valid and operands SHALL be held by the requester until it is accepted.
REQ-027 last_grant updates only on an accept.

Reset
REQ-028 While rst=1: state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_out=0, resp_flags=0, flags_q=0, operand register=0, last_grant=1.
REQ-029 A reset in EXEC or RESP discards the in-flight result; no handshake and no flags_q update occur for it.

Structure
REQ-030 The shared package SHALL hold the ALU control-code constants, flag bit indices (CARRY=2, NEG=1, ZERO=0) and the FSM state encodings.
REQ-031 The round-robin selection SHALL be one sub-module, alu_rr_arb2 (inputs: valid[1:0], last_grant; outputs: grant one-hot).

Verification
REQ-032 req0 only: 105+106, control 0000, resp_ready=1 -> resp_valid 2 cycles after accept, resp_out=211, resp_flags=000, resp_id=0, flags_q=000.
REQ-033 Both requesters valid after reset: req0 adds 2147483648+2147483648, req1 adds 105+106 -> req0 served first with resp_out=0, resp_flags=101, flags_q=101; req1 served next with 211, and flags_q stays 101.
REQ-034 Both requesters held valid for 4 operations with resp_ready=1 -> grants alternate 0,1,0,1, and each pair of consecutive results is separated by exactly 2 cycles.
REQ-035 resp_ready held at 0 for 5 cycles during RESP -> resp_out, resp_flags and resp_id are stable, and req_ready=00 throughout.
REQ-036 rst asserted in EXEC -> next cycle state=IDLE, resp_valid=0, flags_q=000; a later request completes normally.
REQ-037 req1 shift, control 1100, input1=-259, input2=8, FLAG_SRC=0 -> resp_out=-2 (0xFFFFFFFE, arithmetic shift by input2), resp_id=1, flags_q unchanged.
